fiber_pe_arbiter: RTL and testbench
===================================

# fiber_pe_arbiter

Round-robin arbiter that shares the single PE request channel of the `fiber` cache between `NUM_PE` processing elements. It captures one request at a time (FETCH, READ, WRITE or CONSUME) and replays it to the cache. For READ and CONSUME it then holds the grant until the returned data word has been delivered to the requesting PE. It sits between the PE crossbar and the `fiber` PE-side ports.

## Interface
Parameters:
- `NUM_PE`, 4, number of requesting PEs (≥2)
- `ADDR_WIDTH`, 64, request address width
- `DATA_WIDTH`, 16, data word width

Ports (clock and reset first):
- `i_clk`  in  1  single clock; all logic on the rising edge
- `i_reset`  in  1  synchronous reset, active-high
- `i_pe_req_type`  in  4*NUM_PE  per-PE one-hot request type; PE k uses bits [4k+3:4k]; FETCH=0001, READ=0010, WRITE=0100, CONSUME=1000
- `i_pe_addr`  in  ADDR_WIDTH*NUM_PE  per-PE address, packed the same way
- `i_pe_wdata`  in  DATA_WIDTH*NUM_PE  per-PE write data, used for WRITE only
- `i_pe_valid`  in  NUM_PE  per-PE request valid
- `o_pe_ready`  out  NUM_PE  per-PE request accept, at most one bit set
- `o_pe_rdata`  out  DATA_WIDTH  return data, broadcast to all PEs
- `o_pe_rdata_valid`  out  NUM_PE  return valid for the granted PE only
- `i_pe_rdata_ready`  in  NUM_PE  per-PE return ready
- `o_request_type`  out  4  to cache `i_request_type`
- `o_addr`  out  ADDR_WIDTH  to cache `i_addr`
- `o_data`  out  DATA_WIDTH  to cache `i_data`
- `o_type_valid`  out  1  to cache `i_type_valid`
- `i_type_ready`  in  1  from cache `o_type_ready`
- `i_cache_data`  in  DATA_WIDTH  from cache `o_pe_data_o`
- `i_cache_data_valid`  in  1  from cache `o_pe_data_o_valid`
- `o_cache_data_ready`  out  1  to cache `i_pe_data_o_ready`
- `o_grant`  out  NUM_PE  one-hot owner of the channel; 0 in IDLE
- `o_illegal`  out  1  one-cycle pulse when a non-one-hot request type is dropped

## Operation
- FSM states: IDLE, ISSUE, WAIT_DATA. Reset state is IDLE. The round-robin pointer `rr_ptr` resets to 0.
- **IDLE:**
  - Winner = first k with `i_pe_valid[k]`, searching k = rr_ptr, rr_ptr+1, … modulo NUM_PE.
  - `o_pe_ready[winner]` = 1 combinationally; this is the accept.
  - On accept, register type, address and wdata, and set `o_grant` to the winner.
  - If the type is one-hot, go to ISSUE. Otherwise pulse `o_illegal` next cycle, set rr_ptr = winner+1, stay in IDLE, and do not touch the cache.
- **ISSUE:**
  - `o_type_valid` = 1 with the registered fields. Fields stay stable until `i_type_ready` is seen.
  - On `o_type_valid & i_type_ready`: READ or CONSUME goes to WAIT_DATA. FETCH or WRITE goes to IDLE, with rr_ptr = grant index+1 mod NUM_PE.
- **WAIT_DATA:**
  - `o_pe_rdata` = `i_cache_data`.
  - `o_pe_rdata_valid[g]` = `i_cache_data_valid`.
  - `o_cache_data_ready` = `i_pe_rdata_ready[g]`.
  - On handshake, go to IDLE with rr_ptr = g+1.
  - Outside WAIT_DATA: `o_cache_data_ready` = 0 and `o_pe_rdata_valid` = 0.
- rr_ptr arithmetic wraps modulo NUM_PE; (NUM_PE-1)+1 → 0.
- `o_pe_ready` is 0 in ISSUE and WAIT_DATA. Only one request is outstanding at a time.
- A PE may drop `i_pe_valid` before it is accepted; no state is kept for it.

## Timing
- **Reset values:** all outputs 0: `o_pe_ready`, `o_pe_rdata_valid`, `o_type_valid`, `o_request_type`, `o_addr`, `o_data`, `o_cache_data_ready`, `o_grant`, `o_illegal`. `o_pe_rdata` = 0 outside WAIT_DATA.
- **Accept to issue:** accept in cycle N means `o_type_valid` = 1 in cycle N+1.
- **FETCH/WRITE throughput:** one request per 2 cycles when the cache is always ready.
- **READ/CONSUME latency:** after the type handshake in cycle M, the PE return path is live from cycle M+1.
- `i_type_ready` low: ISSUE is held indefinitely and all fields stay stable.
- `i_cache_data_valid` arriving while in IDLE or ISSUE is not acknowledged (ready = 0).
- `i_reset` mid-ISSUE or mid-WAIT_DATA: the next state is IDLE, the request is discarded, rr_ptr = 0, and no partial handshake is completed.
- **Simultaneous valids in IDLE:** only the rr winner sees ready; the others hold their request.
- **Same-cycle case:** a returning PE re-requesting in the cycle after its completion loses to any other valid PE, because rr_ptr has advanced past it.

## Test plan
- **Reset:** assert `i_reset` for 3 cycles with all PE valids high → every output 0, grant 0. Release → PE0 accepted first.
- **FETCH fairness:** all 4 PEs issue FETCH, cache ready tied 1 → grant order 0,1,2,3,0, one issue every 2 cycles. The cache sees `o_addr` = each PE's address (e.g. 0x00000000FFFFFFFF for PE0).
- **CONSUME return:** PE2 issues CONSUME; the cache returns 0x0000 with valid after 3 cycles; PE2 holds ready low 2 cycles then high → `o_pe_rdata_valid` = 0100 until the handshake. `o_pe_ready` stays 0 for all PEs until then, then the FSM returns to IDLE.
- **Back-pressure:** `i_type_ready` low 5 cycles during ISSUE of WRITE addr 0x10, data 0xBEEF → `o_type_valid`, `o_addr` and `o_data` stay constant for all 5 cycles.
- **Illegal type:** PE1 sends type 0011 → `o_pe_ready[1]` pulses, `o_illegal` pulses 1 cycle, `o_type_valid` never rises, next grant goes to PE2 if it is valid.
- **Mid-op reset:** assert `i_reset` during WAIT_DATA of PE3's READ → the next cycle is IDLE with `o_cache_data_ready` = 0, `o_grant` = 0 and rr_ptr = 0.

Source files
------------

// File: rtl/fiber_pe_arbiter.sv
// Round-robin arbiter sharing the fiber cache PE request channel between NUM_PE
// processing elements; one request outstanding, READ/CONSUME hold until data returns.
module fiber_pe_arbiter #(
  parameter int NUM_PE     = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [4*NUM_PE-1:0]          i_pe_req_type,
  input  logic [ADDR_WIDTH*NUM_PE-1:0] i_pe_addr,
  input  logic [DATA_WIDTH*NUM_PE-1:0] i_pe_wdata,
  input  logic [NUM_PE-1:0]            i_pe_valid,
  output logic [NUM_PE-1:0]            o_pe_ready,
  output logic [DATA_WIDTH-1:0]        o_pe_rdata,
  output logic [NUM_PE-1:0]            o_pe_rdata_valid,
  input  logic [NUM_PE-1:0]            i_pe_rdata_ready,
  output logic [3:0]                   o_request_type,
  output logic [ADDR_WIDTH-1:0]        o_addr,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_type_valid,
  input  logic                         i_type_ready,
  input  logic [DATA_WIDTH-1:0]        i_cache_data,
  input  logic                         i_cache_data_valid,
  output logic                         o_cache_data_ready,
  output logic [NUM_PE-1:0]            o_grant,
  output logic                         o_illegal
);

  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] winner_idx;
  logic             found;
  logic [3:0]       win_type;
  logic             win_legal;
  logic             accept;
  logic             in_wait;
  logic             wants_data;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (int'(p) >= NUM_PE - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  // NOTE: combinational blocks use blocking '=' and give every output a default
  // up front, so no path leaves a signal unassigned and a latch is never inferred.
  always_comb begin : rr_search
    logic [PTR_W-1:0] idx;
    found      = 1'b0;
    winner_idx = '0;
    idx        = rr_ptr;
    for (int k = 0; k < NUM_PE; k++) begin
      if (!found && i_pe_valid[idx]) begin
        found      = 1'b1;
        winner_idx = idx;
      end
      idx = next_ptr(idx);
    end
  end

  assign win_type   = i_pe_req_type[4*winner_idx +: 4];
  assign win_legal  = (win_type != 4'b0000) && ((win_type & (win_type - 4'd1)) == 4'b0000);
  // Reset masks the accept so nothing is captured while reset is held.
  assign accept     = (state == IDLE) && found && !i_reset;
  assign o_pe_ready = accept ? (NUM_PE'(1) << winner_idx) : '0;

  // READ (0010) or CONSUME (1000) wait for a returned data word.
  assign wants_data = o_request_type[1] | o_request_type[3];

  // Return path is only live in WAIT_DATA; reset blocks any partial handshake.
  assign in_wait            = (state == WAIT_DATA) && !i_reset;
  assign o_type_valid       = (state == ISSUE) && !i_reset;
  assign o_pe_rdata         = in_wait ? i_cache_data : '0;
  assign o_pe_rdata_valid   = (in_wait && i_cache_data_valid) ? (NUM_PE'(1) << grant_idx) : '0;
  assign o_cache_data_ready = in_wait && i_pe_rdata_ready[grant_idx];

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      grant_idx      <= '0;
      o_grant        <= '0;
      o_request_type <= '0;
      o_addr         <= '0;
      o_data         <= '0;
      o_illegal      <= 1'b0;
    end else begin
      o_illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            o_request_type <= win_type;
            o_addr         <= i_pe_addr[ADDR_WIDTH*winner_idx +: ADDR_WIDTH];
            o_data         <= i_pe_wdata[DATA_WIDTH*winner_idx +: DATA_WIDTH];
            grant_idx      <= winner_idx;
            if (win_legal) begin
              o_grant <= NUM_PE'(1) << winner_idx;
              state   <= ISSUE;
            end else begin
              // Dropped request: flag it and move fairness past the offender.
              o_illegal <= 1'b1;
              rr_ptr    <= next_ptr(winner_idx);
            end
          end
        end
        ISSUE: begin
          if (i_type_ready) begin
            if (wants_data) begin
              state <= WAIT_DATA;
            end else begin
              state   <= IDLE;
              o_grant <= '0;
              rr_ptr  <= next_ptr(grant_idx);
            end
          end
        end
        WAIT_DATA: begin
          if (i_cache_data_valid && i_pe_rdata_ready[grant_idx]) begin
            state   <= IDLE;
            o_grant <= '0;
            rr_ptr  <= next_ptr(grant_idx);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fiber_pe_arbiter.sv
// Self-checking bench for fiber_pe_arbiter: scoreboarded cache issues and PE returns,
// a vector table of single requests, and hand-written multi-cycle sequences.
module tb_fiber_pe_arbiter;

  localparam int NUM_PE = 4;
  localparam int AW     = 64;
  localparam int DW     = 16;

  localparam logic [3:0] T_FETCH   = 4'b0001;
  localparam logic [3:0] T_READ    = 4'b0010;
  localparam logic [3:0] T_WRITE   = 4'b0100;
  localparam logic [3:0] T_CONSUME = 4'b1000;

  logic                   i_clk;
  logic                   i_reset;
  logic [4*NUM_PE-1:0]    i_pe_req_type;
  logic [AW*NUM_PE-1:0]   i_pe_addr;
  logic [DW*NUM_PE-1:0]   i_pe_wdata;
  logic [NUM_PE-1:0]      i_pe_valid;
  logic [NUM_PE-1:0]      o_pe_ready;
  logic [DW-1:0]          o_pe_rdata;
  logic [NUM_PE-1:0]      o_pe_rdata_valid;
  logic [NUM_PE-1:0]      i_pe_rdata_ready;
  logic [3:0]             o_request_type;
  logic [AW-1:0]          o_addr;
  logic [DW-1:0]          o_data;
  logic                   o_type_valid;
  logic                   i_type_ready;
  logic [DW-1:0]          i_cache_data;
  logic                   i_cache_data_valid;
  logic                   o_cache_data_ready;
  logic [NUM_PE-1:0]      o_grant;
  logic                   o_illegal;

  fiber_pe_arbiter #(.NUM_PE(NUM_PE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_pe_req_type(i_pe_req_type), .i_pe_addr(i_pe_addr), .i_pe_wdata(i_pe_wdata),
    .i_pe_valid(i_pe_valid), .o_pe_ready(o_pe_ready),
    .o_pe_rdata(o_pe_rdata), .o_pe_rdata_valid(o_pe_rdata_valid),
    .i_pe_rdata_ready(i_pe_rdata_ready),
    .o_request_type(o_request_type), .o_addr(o_addr), .o_data(o_data),
    .o_type_valid(o_type_valid), .i_type_ready(i_type_ready),
    .i_cache_data(i_cache_data), .i_cache_data_valid(i_cache_data_valid),
    .o_cache_data_ready(o_cache_data_ready),
    .o_grant(o_grant), .o_illegal(o_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]        typ;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data;
    logic [NUM_PE-1:0] grant;
    bit                chk_data;
  } iss_t;

  typedef struct {
    logic [DW-1:0]     data;
    logic [NUM_PE-1:0] vld;
  } ret_t;

  typedef struct {
    string         name;
    int            pe;
    logic [3:0]    typ;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            illegal;
  } vec_t;

  iss_t iss_q[$];
  ret_t ret_q[$];
  iss_t exp_i;
  ret_t exp_r;
  vec_t vecs[7];
  logic [AW-1:0] fair_addr[NUM_PE];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int pe, input logic [3:0] t, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    i_pe_req_type[pe*4 +: 4] = t;
    i_pe_addr[pe*AW +: AW]   = a;
    i_pe_wdata[pe*DW +: DW]  = d;
  endtask

  task automatic push_iss(input int pe, input logic [3:0] t, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    iss_t e;
    e.typ = t; e.addr = a; e.data = d;
    e.grant = 4'b0001 << pe;
    e.chk_data = (t == T_WRITE);
    iss_q.push_back(e);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_accept(input int pe, input string name);
    int n = 0;
    logic [NUM_PE-1:0] oh;
    oh = 4'b0001 << pe;
    @(negedge i_clk);
    while (!o_pe_ready[pe] && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check({name, "_accept"}, 64'(o_pe_ready), 64'(oh));
  endtask

  task automatic wait_issue(input string name);
    int n = 0;
    @(negedge i_clk);
    while (!o_type_valid && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check({name, "_issue"}, 64'(o_type_valid), 64'd1);
  endtask

  // Cache-side scoreboard: every type handshake must match the oldest expectation.
  always @(negedge i_clk) begin
    if (!i_reset && o_type_valid && i_type_ready) begin
      if (iss_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_issue: got type 0x%0h addr 0x%0h expected no issue",
                 o_request_type, o_addr);
      end else begin
        exp_i = iss_q.pop_front();
        check("issue_type",  64'(o_request_type), 64'(exp_i.typ));
        check("issue_addr",  o_addr, exp_i.addr);
        check("issue_grant", 64'(o_grant), 64'(exp_i.grant));
        if (exp_i.chk_data) check("issue_data", 64'(o_data), 64'(exp_i.data));
      end
    end
  end

  // PE-side return scoreboard.
  always @(negedge i_clk) begin
    if (!i_reset && |(o_pe_rdata_valid & i_pe_rdata_ready)) begin
      if (ret_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_return: got valid 0x%0h expected none", o_pe_rdata_valid);
      end else begin
        exp_r = ret_q.pop_front();
        check("ret_data",  64'(o_pe_rdata), 64'(exp_r.data));
        check("ret_valid", 64'(o_pe_rdata_valid), 64'(exp_r.vld));
        check("ret_cache_ready", 64'(o_cache_data_ready), 64'd1);
      end
    end
  end

  initial begin
    int t_prev;
    ret_t r;

    vecs[0] = '{"v_fetch_pe3",   3, T_FETCH,   64'h3000_0000_0000_0040, 16'h1111, 16'h0000, 1'b0};
    vecs[1] = '{"v_write_pe0",   0, T_WRITE,   64'h0000_0000_0000_0010, 16'hBEEF, 16'h0000, 1'b0};
    vecs[2] = '{"v_read_pe1",    1, T_READ,    64'h0000_0000_0000_0020, 16'h2222, 16'h1234, 1'b0};
    vecs[3] = '{"v_consume_pe2", 2, T_CONSUME, 64'hFFFF_FFFF_FFFF_FFF8, 16'h3333, 16'hFFFF, 1'b0};
    vecs[4] = '{"v_illegal_0011", 1, 4'b0011,  64'h0000_0000_0000_0030, 16'h4444, 16'h0000, 1'b1};
    vecs[5] = '{"v_illegal_0000", 3, 4'b0000,  64'h0000_0000_0000_0038, 16'h5555, 16'h0000, 1'b1};
    vecs[6] = '{"v_read_pe3",    3, T_READ,    64'h7FFF_0000_0000_0000, 16'h6666, 16'h8001, 1'b0};

    fair_addr[0] = 64'h0000_0000_FFFF_FFFF;
    fair_addr[1] = 64'h0000_0001_0000_0004;
    fair_addr[2] = 64'h8000_0000_0000_0008;
    fair_addr[3] = 64'hFFFF_FFFF_FFFF_FFF0;

    // Reset with every PE requesting and the return path fully driven.
    i_reset            = 1'b1;
    i_pe_req_type      = '0;
    i_pe_addr          = '0;
    i_pe_wdata         = '0;
    i_type_ready       = 1'b1;
    i_cache_data       = 16'h5A5A;
    i_cache_data_valid = 1'b1;
    i_pe_rdata_ready   = '1;
    for (int k = 0; k < NUM_PE; k++) set_req(k, T_FETCH, fair_addr[k], DW'(16'hA000 + k));
    i_pe_valid = '1;

    repeat (3) begin
      @(negedge i_clk);
      check("rst_pe_ready",     64'(o_pe_ready), 64'd0);
      check("rst_rdata_valid",  64'(o_pe_rdata_valid), 64'd0);
      check("rst_rdata",        64'(o_pe_rdata), 64'd0);
      check("rst_type_valid",   64'(o_type_valid), 64'd0);
      check("rst_request_type", 64'(o_request_type), 64'd0);
      check("rst_addr",         o_addr, 64'd0);
      check("rst_data",         64'(o_data), 64'd0);
      check("rst_cache_ready",  64'(o_cache_data_ready), 64'd0);
      check("rst_grant",        64'(o_grant), 64'd0);
      check("rst_illegal",      64'(o_illegal), 64'd0);
    end

    // Fairness: all four FETCH continuously, cache always ready.
    for (int i = 0; i < 5; i++) push_iss(i % NUM_PE, T_FETCH, fair_addr[i % NUM_PE], 16'h0);
    step();
    i_reset            = 1'b0;
    i_cache_data_valid = 1'b0;
    i_pe_rdata_ready   = '0;
    @(negedge i_clk);
    check("post_reset_ready", 64'(o_pe_ready), 64'd1);
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_issue("fair");
      if (i > 0) check("fair_spacing", 64'(cyc - t_prev), 64'd2);
      t_prev = cyc;
    end
    step();
    i_pe_valid = '0;

    // Table of single requests.
    foreach (vecs[i]) begin
      step();
      set_req(vecs[i].pe, vecs[i].typ, vecs[i].addr, vecs[i].wdata);
      i_pe_valid[vecs[i].pe] = 1'b1;
      if (!vecs[i].illegal) push_iss(vecs[i].pe, vecs[i].typ, vecs[i].addr, vecs[i].wdata);
      wait_accept(vecs[i].pe, vecs[i].name);
      step();
      i_pe_valid[vecs[i].pe] = 1'b0;
      if (vecs[i].illegal) begin
        @(negedge i_clk);
        check({vecs[i].name, "_illegal"},    64'(o_illegal), 64'd1);
        check({vecs[i].name, "_no_issue"},   64'(o_type_valid), 64'd0);
        check({vecs[i].name, "_grant"},      64'(o_grant), 64'd0);
        @(negedge i_clk);
        check({vecs[i].name, "_illegal_end"}, 64'(o_illegal), 64'd0);
      end else begin
        wait_issue(vecs[i].name);
        step();
        if (vecs[i].typ == T_READ || vecs[i].typ == T_CONSUME) begin
          @(negedge i_clk);
          check({vecs[i].name, "_wait_ready"},  64'(o_pe_ready), 64'd0);
          check({vecs[i].name, "_wait_rvalid"}, 64'(o_pe_rdata_valid), 64'd0);
          step();
          i_cache_data       = vecs[i].rdata;
          i_cache_data_valid = 1'b1;
          i_pe_rdata_ready[vecs[i].pe] = 1'b1;
          r.data = vecs[i].rdata;
          r.vld  = 4'b0001 << vecs[i].pe;
          ret_q.push_back(r);
          @(negedge i_clk);
          check({vecs[i].name, "_cache_ready"}, 64'(o_cache_data_ready), 64'd1);
          step();
          i_cache_data_valid = 1'b0;
          i_pe_rdata_ready   = '0;
        end
      end
    end

    // CONSUME from PE2: data after 3 cycles, PE2 stalls the return 2 cycles;
    // PE0 requests meanwhile and must not be accepted until completion.
    step();
    set_req(2, T_CONSUME, 64'h0000_0000_0000_0200, 16'h0);
    i_pe_valid[2] = 1'b1;
    push_iss(2, T_CONSUME, 64'h0000_0000_0000_0200, 16'h0);
    wait_accept(2, "cons");
    step();
    i_pe_valid[2] = 1'b0;
    wait_issue("cons");
    set_req(0, T_FETCH, 64'h0000_0000_0000_0A00, 16'h0);
    push_iss(0, T_FETCH, 64'h0000_0000_0000_0A00, 16'h0);
    repeat (3) begin
      step();
      i_pe_valid[0] = 1'b1;
      @(negedge i_clk);
      check("cons_lat_rvalid", 64'(o_pe_rdata_valid), 64'd0);
      check("cons_lat_ready",  64'(o_pe_ready), 64'd0);
      check("cons_lat_cready", 64'(o_cache_data_ready), 64'd0);
    end
    step();
    i_cache_data       = 16'h0000;
    i_cache_data_valid = 1'b1;
    repeat (2) begin
      @(negedge i_clk);
      check("cons_stall_rvalid", 64'(o_pe_rdata_valid), 64'b0100);
      check("cons_stall_cready", 64'(o_cache_data_ready), 64'd0);
      check("cons_stall_ready",  64'(o_pe_ready), 64'd0);
      step();
    end
    i_pe_rdata_ready[2] = 1'b1;
    r.data = 16'h0000;
    r.vld  = 4'b0100;
    ret_q.push_back(r);
    @(negedge i_clk);
    check("cons_hs_cready", 64'(o_cache_data_ready), 64'd1);
    step();
    i_cache_data_valid = 1'b0;
    i_pe_rdata_ready   = '0;
    @(negedge i_clk);
    check("cons_idle_grant", 64'(o_grant), 64'd0);
    check("cons_next_ready", 64'(o_pe_ready), 64'b0001);
    step();
    i_pe_valid[0] = 1'b0;
    wait_issue("cons_next");
    step();

    // Back-pressure: WRITE held in ISSUE for 5 cycles.
    i_type_ready = 1'b0;
    set_req(0, T_WRITE, 64'h10, 16'hBEEF);
    i_pe_valid[0] = 1'b1;
    push_iss(0, T_WRITE, 64'h10, 16'hBEEF);
    wait_accept(0, "bp");
    step();
    i_pe_valid[0] = 1'b0;
    repeat (5) begin
      @(negedge i_clk);
      check("bp_type_valid", 64'(o_type_valid), 64'd1);
      check("bp_addr",       o_addr, 64'h10);
      check("bp_data",       64'(o_data), 64'hBEEF);
      check("bp_type",       64'(o_request_type), 64'(T_WRITE));
      step();
    end
    i_type_ready = 1'b1;
    wait_issue("bp");
    step();

    // Illegal type from PE1 while PE2 is also requesting.
    set_req(1, 4'b0011, 64'h44, 16'h0);
    set_req(2, T_FETCH, 64'h0000_0000_0000_0220, 16'h0);
    i_pe_valid[1] = 1'b1;
    i_pe_valid[2] = 1'b1;
    push_iss(2, T_FETCH, 64'h0000_0000_0000_0220, 16'h0);
    wait_accept(1, "ill");
    step();
    i_pe_valid[1] = 1'b0;
    @(negedge i_clk);
    check("ill_pulse",      64'(o_illegal), 64'd1);
    check("ill_no_issue",   64'(o_type_valid), 64'd0);
    check("ill_next_ready", 64'(o_pe_ready), 64'b0100);
    step();
    i_pe_valid[2] = 1'b0;
    wait_issue("ill_next");
    step();

    // Reset in the middle of PE3's READ return.
    set_req(3, T_READ, 64'h0000_0000_0000_0330, 16'h0);
    i_pe_valid[3] = 1'b1;
    push_iss(3, T_READ, 64'h0000_0000_0000_0330, 16'h0);
    wait_accept(3, "mrst");
    step();
    i_pe_valid[3] = 1'b0;
    wait_issue("mrst");
    step();
    i_reset             = 1'b1;
    i_cache_data        = 16'hDEAD;
    i_cache_data_valid  = 1'b1;
    i_pe_rdata_ready[3] = 1'b1;
    set_req(3, T_FETCH, 64'h0000_0000_0000_0338, 16'h0);
    set_req(0, T_FETCH, 64'h0000_0000_0000_0008, 16'h0);
    i_pe_valid[0] = 1'b1;
    i_pe_valid[3] = 1'b1;
    @(negedge i_clk);
    check("mrst_cready_in_rst", 64'(o_cache_data_ready), 64'd0);
    check("mrst_rvalid_in_rst", 64'(o_pe_rdata_valid), 64'd0);
    check("mrst_ready_in_rst",  64'(o_pe_ready), 64'd0);
    push_iss(0, T_FETCH, 64'h0000_0000_0000_0008, 16'h0);
    step();
    i_reset            = 1'b0;
    i_cache_data_valid = 1'b0;
    i_pe_rdata_ready   = '0;
    @(negedge i_clk);
    check("mrst_grant",      64'(o_grant), 64'd0);
    check("mrst_cready",     64'(o_cache_data_ready), 64'd0);
    check("mrst_type_valid", 64'(o_type_valid), 64'd0);
    check("mrst_rr_zero",    64'(o_pe_ready), 64'b0001);
    step();
    i_pe_valid = '0;
    wait_issue("mrst_next");

    repeat (3) step();
    check("iss_q_empty", 64'(iss_q.size()), 64'd0);
    check("ret_q_empty", 64'(ret_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
